alu_seq: RTL and testbench

- Multi-byte operation sequencer built around the existing 8-bit `alu`.
- Latches two NBYTES-wide operands and an ALU op code on `start`.
- Drives one byte per cycle through the ALU, LSB first, chaining carry/borrow between bytes.
- Returns the assembled wide result with aggregate zero and final carry flags; used by the calculator datapath for 16/32-bit arithmetic on the 8-bit ALU.

---
 rtl/alu_seq_pkg.sv | 25 ++
 rtl/alu_seq_alu.sv | 34 +++
 rtl/alu_seq.sv | 116 +++++++++++
 tb/tb_alu_seq.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the 8-bit ALU and the multi-byte sequencer.
// Op codes and sequencer state encodings live here only.
package alu_seq_pkg;

  localparam int AC_N = 3;

  localparam logic [AC_N-1:0] AC_AD = 3'd0;
  localparam logic [AC_N-1:0] AC_SB = 3'd1;
  localparam logic [AC_N-1:0] AC_AN = 3'd2;
  localparam logic [AC_N-1:0] AC_OR = 3'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  // Only add/subtract propagate carry/borrow between bytes.
  function automatic logic chains(
    input logic [AC_N-1:0] cs
  );
    return (cs == AC_AD) || (cs == AC_SB);
  endfunction

endpackage

// File: rtl/alu_seq_alu.sv
// 8-bit combinational ALU; SB reports borrow on carry_out.
// Unlisted op codes produce A xor B with no carry.
module alu
  import alu_seq_pkg::*;
(
  input  logic [AC_N-1:0] CS,
  input  logic [7:0]      data_a,
  input  logic [7:0]      data_b,
  input  logic            carry_in,
  output logic [7:0]      S,
  output logic            zero,
  output logic            carry_out
);

  logic [8:0] res9;

  always_comb begin
    res9 = '0;
    unique case (1'b1)
      (CS == AC_AD): res9 = {1'b0, data_a} + {1'b0, data_b}
                          + {8'd0, carry_in};
      (CS == AC_SB): res9 = {1'b0, data_a} - {1'b0, data_b}
                          - {8'd0, carry_in};
      (CS == AC_AN): res9 = {1'b0, data_a & data_b};
      (CS == AC_OR): res9 = {1'b0, data_a | data_b};
      default:       res9 = {1'b0, data_a ^ data_b};
    endcase
  end

  assign S         = res9[7:0];
  assign carry_out = res9[8];
  assign zero      = (res9[7:0] == 8'd0);

endmodule

// File: rtl/alu_seq.sv
// Multi-byte sequencer: feeds one byte per cycle through the 8-bit
// ALU, LSB first, chaining carry/borrow and accumulating zero.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [AC_N-1:0]       op,
  input  logic                  carry_in,
  input  logic [8*NBYTES-1:0]   opa,
  input  logic [8*NBYTES-1:0]   opb,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   result,
  output logic                  zero,
  output logic                  carry_out
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  seq_state_e      state_q;
  logic [IW-1:0]   idx_q;
  logic [AC_N-1:0] op_q;
  logic [W-1:0]    opa_q;
  logic [W-1:0]    opb_q;
  logic [W-1:0]    res_q;
  logic            cc_q;
  logic            zacc_q;
  logic            busy_q;
  logic            done_q;
  logic            zero_q;
  logic            co_q;

  logic [7:0]      a_byte;
  logic [7:0]      b_byte;
  logic [7:0]      s_byte;
  logic            alu_z;
  logic            alu_co;
  logic            last;

  assign a_byte = opa_q[{idx_q, 3'b000} +: 8];
  assign b_byte = opb_q[{idx_q, 3'b000} +: 8];
  assign last   = (idx_q == IW'(NBYTES - 1));

  alu u_alu (
    .CS        (op_q),
    .data_a    (a_byte),
    .data_b    (b_byte),
    .carry_in  (cc_q),
    .S         (s_byte),
    .zero      (alu_z),
    .carry_out (alu_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      op_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      cc_q    <= 1'b0;
      zacc_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
      co_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            op_q    <= op;
            opa_q   <= opa;
            opb_q   <= opb;
            cc_q    <= chains(op) & carry_in;
            idx_q   <= '0;
            zacc_q  <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          res_q[{idx_q, 3'b000} +: 8] <= s_byte;
          zacc_q <= zacc_q & alu_z;
          cc_q   <= chains(op_q) & alu_co;
          if (last) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            zero_q  <= zacc_q & alu_z;
            co_q    <= chains(op_q) & alu_co;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = res_q;
  assign zero      = zero_q;
  assign carry_out = co_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (NBYTES=2) against a wide-word
// arithmetic reference model.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int NB = 2;
  localparam int W  = 8 * NB;

  logic            clk;
  logic            rst;
  logic            start;
  logic [AC_N-1:0] op;
  logic            carry_in;
  logic [W-1:0]    opa;
  logic [W-1:0]    opb;
  logic            busy;
  logic            done;
  logic [W-1:0]    result;
  logic            zero;
  logic            carry_out;

  int n_checks;
  int n_fail;

  alu_seq #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .carry_in  (carry_in),
    .opa       (opa),
    .opb       (opb),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .zero      (zero),
    .carry_out (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Whole-word reference: bit W carries the final carry/borrow.
  function automatic logic [W:0] model(
    input logic [W-1:0]    a,
    input logic [W-1:0]    b,
    input logic [AC_N-1:0] o,
    input logic            ci
  );
    logic [W:0] r;
    case (o)
      AC_AD:   r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
      AC_SB:   r = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, ci};
      AC_AN:   r = {1'b0, a & b};
      default: r = {1'b0, a | b};
    endcase
    return r;
  endfunction

  task automatic run_op(
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    input  logic [AC_N-1:0] o,
    input  logic            ci,
    output logic [W-1:0]    r,
    output logic            z,
    output logic            c,
    output int              busy_n,
    output int              done_n,
    output int              done_at
  );
    r = '0; z = 1'b0; c = 1'b0;
    busy_n = 0; done_n = 0; done_at = 0;
    @(negedge clk);
    opa = a; opb = b; op = o; carry_in = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    opa = W'($urandom); opb = W'($urandom);
    op = AC_N'($urandom_range(0, 3)); carry_in = 1'($urandom);
    for (int k = 1; k <= NB + 3; k++) begin
      if (busy) busy_n++;
      if (done) begin
        done_n++; done_at = k;
        r = result; z = zero; c = carry_out;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; op = AC_AD; carry_in = 1'b0;
    opa = '0; opb = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, result, zero, carry_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b res=%h z=%b c=%b, need all 0",
               busy, done, result, zero, carry_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [W-1:0]    ta  [6] = '{16'h12FF, 16'hFFFF, 16'h0100, 16'h0000, 16'hF0F0, 16'h0000};
    logic [W-1:0]    tb_ [6] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0FF0, 16'h0000};
    logic [AC_N-1:0] to  [6] = '{AC_AD, AC_AD, AC_SB, AC_SB, AC_AN, AC_OR};
    logic            tci [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [W-1:0]    tr  [6] = '{16'h1300, 16'h0000, 16'h00FF, 16'hFFFF, 16'h00F0, 16'h0000};
    logic            tz  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic            tc  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [W-1:0] r;
    logic z, c;
    int bn, dn, da;
    for (int i = 0; i < 6; i++) begin
      run_op(ta[i], tb_[i], to[i], tci[i], r, z, c, bn, dn, da);
      n_checks++;
      if (r !== tr[i] || z !== tz[i] || c !== tc[i]) begin
        n_fail++;
        $display("FAIL directed_%0d: got res=%h z=%b c=%b, need res=%h z=%b c=%b",
                 i, r, z, c, tr[i], tz[i], tc[i]);
      end
      n_checks++;
      if (bn !== NB + 1 || dn !== 1 || da !== NB + 1) begin
        n_fail++;
        $display("FAIL timing_%0d: got busy_cycles=%0d dones=%0d done_at=%0d, need %0d 1 %0d",
                 i, bn, dn, da, NB + 1, NB + 1);
      end
      n_checks++;
      if (result !== tr[i] || zero !== tz[i] || carry_out !== tc[i]) begin
        n_fail++;
        $display("FAIL hold_%0d: got res=%h z=%b c=%b, need res=%h z=%b c=%b",
                 i, result, zero, carry_out, tr[i], tz[i], tc[i]);
      end
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a, b, r;
    logic [AC_N-1:0] o;
    logic ci, z, c;
    logic [W:0] m;
    int bn, dn, da;
    for (int i = 0; i < 24; i++) begin
      a = W'($urandom); b = W'($urandom);
      if (i % 6 == 0) b = a;
      o = AC_N'($urandom_range(0, 3)); ci = 1'($urandom);
      m = model(a, b, o, ci);
      run_op(a, b, o, ci, r, z, c, bn, dn, da);
      n_checks++;
      if (r !== m[W-1:0] || z !== (m[W-1:0] == '0) || c !== m[W] || dn !== 1) begin
        n_fail++;
        $display("FAIL random_%0d op=%0d a=%h b=%h ci=%b: got res=%h z=%b c=%b dones=%0d, need res=%h z=%b c=%b dones=1",
                 i, o, a, b, ci, r, z, c, dn, m[W-1:0], (m[W-1:0] == '0), m[W]);
      end
    end
  endtask

  task automatic test_busy_ignore;
    int dn;
    logic [W-1:0] r;
    dn = 0; r = '0;
    @(negedge clk);
    opa = 16'h1234; opb = 16'h0101; op = AC_AD; carry_in = 1'b0; start = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= NB + 6; k++) begin
      if (done) begin dn++; r = result; end
      start = (k <= NB + 1);
      opa = 16'hFFFF; opb = 16'hFFFF; op = AC_SB; carry_in = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    n_checks++;
    if (dn !== 1 || r !== 16'h1335) begin
      n_fail++;
      $display("FAIL busy_ignore: got dones=%0d res=%h, need dones=1 res=1335", dn, r);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_ignore_idle: got busy=%b, need 0", busy);
    end
  endtask

  task automatic test_reset_mid_run;
    int dn;
    logic [W-1:0] r;
    logic z, c;
    int bn, dn2, da;
    dn = 0;
    @(negedge clk);
    opa = 16'h1111; opb = 16'h2222; op = AC_AD; carry_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, done, result, zero, carry_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_run: got busy=%b done=%b res=%h z=%b c=%b, need all 0",
               busy, done, result, zero, carry_out);
    end
    rst = 1'b0;
    for (int k = 0; k < NB + 3; k++) begin
      if (done) dn++;
      @(negedge clk);
    end
    n_checks++;
    if (dn !== 0) begin
      n_fail++;
      $display("FAIL reset_no_done: got dones=%0d, need 0", dn);
    end
    run_op(16'h00FF, 16'h0001, AC_AD, 1'b1, r, z, c, bn, dn2, da);
    n_checks++;
    if (r !== 16'h0101 || z !== 1'b0 || c !== 1'b0 || dn2 !== 1) begin
      n_fail++;
      $display("FAIL reset_fresh_run: got res=%h z=%b c=%b dones=%0d, need res=0101 z=0 c=0 dones=1",
               r, z, c, dn2);
    end
  endtask

  task automatic test_back_to_back;
    int dn, first, last_k;
    dn = 0; first = 0; last_k = 0;
    @(negedge clk);
    opa = 16'h8000; opb = 16'h8000; op = AC_AD; carry_in = 1'b0; start = 1'b1;
    for (int k = 1; k <= 3 * NB + 6; k++) begin
      @(negedge clk);
      if (done) begin
        dn++; last_k = k;
        if (first == 0) first = k;
      end
    end
    start = 1'b0;
    n_checks++;
    if (dn !== 3 || first !== NB + 1 || last_k !== 3 * NB + 5) begin
      n_fail++;
      $display("FAIL back_to_back: got dones=%0d first=%0d last=%0d, need 3 %0d %0d",
               dn, first, last_k, NB + 1, 3 * NB + 5);
    end
    n_checks++;
    if (result !== 16'h0000 || zero !== 1'b1 || carry_out !== 1'b1) begin
      n_fail++;
      $display("FAIL back_to_back_flags: got res=%h z=%b c=%b, need res=0000 z=1 c=1",
               result, zero, carry_out);
    end
    repeat (NB + 3) @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
